mfsk_mod: RTL

MFSK_MOD -- requirements
Module: mfsk_mod

---
 rtl/mfsk_pkg.sv | 24 ++
 rtl/mfsk_tone_div.sv | 30 +++
 rtl/mfsk_mod.sv | 90 +++++++++
 3 files changed

// File: rtl/mfsk_pkg.sv
// Shared types, default parameters and the Gray decoder for the MFSK modulator.
package mfsk_pkg;

  localparam int SYM_BITS_DEF = 2;
  localparam int DIV_W_DEF    = 8;
  localparam int LEN_W_DEF    = 16;
  localparam int GRAY_W       = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/mfsk_tone_div.sv
// Half-period counter: pulses tog on the last cycle of each half-period.
module mfsk_tone_div
  import mfsk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] hp,
  output logic             tog
);

  logic [DIV_W-1:0] cnt;

  assign tog = en && (cnt == hp - 1'b1);

  // restart wins so a new symbol always begins a fresh half-period
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tog) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mfsk_mod.sv
// MFSK square-wave modulator with phase-continuous symbol chaining.
// Define MFSK_GRAY_EN to Gray-decode sym_data into the tone index.
module mfsk_mod
  import mfsk_pkg::*;
#(
  parameter int SYM_BITS = SYM_BITS_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [(2**SYM_BITS)*DIV_W-1:0]   half_per,
  input  logic [LEN_W-1:0]                 sym_len,
  input  logic                             sym_valid,
  input  logic [SYM_BITS-1:0]              sym_data,
  output logic                             sym_ready,
  output logic                             y,
  output logic                             busy,
  output logic                             underrun
);

  localparam int NT = 2**SYM_BITS;

  state_t              state;
  logic [SYM_BITS-1:0] tone_idx;
  logic [DIV_W-1:0]    hp_sel, hp_eff, hp_q;
  logic [LEN_W-1:0]    len_eff, len_q, sym_cnt;
  logic                last, accept, tog;

`ifdef MFSK_GRAY_EN
  assign tone_idx = SYM_BITS'(gray2bin(GRAY_W'(sym_data)));
`else
  assign tone_idx = sym_data;
`endif

  always_comb begin
    hp_sel = '0;
    for (int i = 0; i < NT; i++) begin
      if (tone_idx == SYM_BITS'(i)) hp_sel = half_per[i*DIV_W +: DIV_W];
    end
  end

  // A zero period or length would stall the counters; treat it as one.
  assign hp_eff  = (hp_sel  == '0) ? DIV_W'(1) : hp_sel;
  assign len_eff = (sym_len == '0) ? LEN_W'(1) : sym_len;

  assign busy      = (state == SEND);
  assign last      = busy && (sym_cnt == len_q - 1'b1);
  assign sym_ready = !busy || last;
  assign accept    = sym_valid && sym_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      y        <= 1'b0;
      underrun <= 1'b0;
      hp_q     <= '0;
      len_q    <= '0;
      sym_cnt  <= '0;
    end else begin
      underrun <= last && !accept;
      if (accept) begin
        hp_q    <= hp_eff;
        len_q   <= len_eff;
        sym_cnt <= '0;
        state   <= SEND;
      end else if (last) begin
        state <= IDLE;
      end else if (busy) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
      // On a chained boundary y keeps running; only a true end parks it low.
      if (last && !accept) begin
        y <= 1'b0;
      end else if (tog) begin
        y <= ~y;
      end
    end
  end

  mfsk_tone_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .restart (accept),
    .hp      (hp_q),
    .tog     (tog)
  );

endmodule
